// File: rtl/tluh_pkg.sv
// tluh_pkg: TL-UH data width, LogicalData opcodes and atomic sequencer state encoding.
package tluh_pkg;
    localparam int TL_DW = 32;
    localparam logic [2:0] LOGIC_XOR  = 3'd0;
    localparam logic [2:0] LOGIC_OR   = 3'd1;
    localparam logic [2:0] LOGIC_AND  = 3'd2;
    localparam logic [2:0] LOGIC_SWAP = 3'd3;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} atomic_state_e;
    function automatic logic op_defined(input logic [2:0] op);
        return op <= LOGIC_SWAP;
    endfunction
endpackage

// File: rtl/logical_unit.sv
// logical_unit: bitwise TL-UH LogicalData operation; SWAP yields op2, undefined opcodes yield 0.
module logical_unit
    import tluh_pkg::*;
(
    input  logic             enable_i,
    input  logic [TL_DW-1:0] op1_i,
    input  logic [TL_DW-1:0] op2_i,
    input  logic [2:0]       operation_i,
    output logic [TL_DW-1:0] result_o,
    output logic             cout_o
);
    always_comb begin
        result_o = !enable_i                     ? '0 :
                   operation_i == LOGIC_XOR  ? op1_i ^ op2_i :
                   operation_i == LOGIC_OR   ? op1_i | op2_i :
                   operation_i == LOGIC_AND  ? op1_i & op2_i :
                   operation_i == LOGIC_SWAP ? op2_i : '0;
        cout_o = 1'b0;
    end
endmodule

// File: rtl/tluh_lu_atomic_ctrl.sv
// tluh_lu_atomic_ctrl: locked read-modify-write sequencer for TL-UH logical atomics.
// Defining TLUH_ATOMIC_TIMEOUT_EN bounds each memory wait to TIMEOUT_CYCLES.
module tluh_lu_atomic_ctrl
    import tluh_pkg::*;
#(
    parameter int AW             = 32,
    parameter int SRCW           = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [AW-1:0]      req_addr_i,
    input  logic [TL_DW-1:0]   req_data_i,
    input  logic [TL_DW/8-1:0] req_mask_i,
    input  logic [2:0]         req_op_i,
    input  logic [SRCW-1:0]    req_source_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [TL_DW-1:0]   rsp_data_o,
    output logic [SRCW-1:0]    rsp_source_o,
    output logic               rsp_error_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [TL_DW-1:0]   mem_wdata_o,
    output logic [TL_DW/8-1:0] mem_wmask_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [TL_DW-1:0]   mem_rdata_i,
    input  logic               mem_err_i,
    output logic               lock_o
);
    atomic_state_e      state;
    logic [TL_DW-1:0]   data, old, lu_result, merged;
    logic [TL_DW/8-1:0] mask;
    logic [2:0]         op;
    logic               timeout;

    logical_unit u_lu (
        .enable_i   (1'b1),
        .op1_i      (old),
        .op2_i      (data),
        .operation_i(op),
        .result_o   (lu_result),
        .cout_o     ()
    );

    always_comb begin
        merged = old;
        for (int i = 0; i < TL_DW / 8; i++)
            merged[i*8 +: 8] = mask[i] ? lu_result[i*8 +: 8] : old[i*8 +: 8];
    end

    assign mem_wdata_o = mem_we_o ? merged : '0;
    assign mem_wmask_o = mem_we_o ? mask : '0;

`ifdef TLUH_ATOMIC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    assign waiting = (state == RD_WAIT || state == WR_WAIT) && !mem_rvalid_i;
    assign timeout = waiting && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wait_cnt <= '0;
        else       wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_source_o <= '0;
            rsp_error_o  <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            lock_o       <= 1'b0;
            data         <= '0;
            old          <= '0;
            mask         <= '0;
            op           <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    mem_addr_o   <= req_addr_i;
                    data         <= req_data_i;
                    mask         <= req_mask_i;
                    op           <= req_op_i;
                    rsp_source_o <= req_source_i;
                    rsp_error_o  <= 1'b0;
                    rsp_data_o   <= '0;
                    req_ready_o  <= 1'b0;
                    lock_o       <= 1'b1;
                    mem_req_o    <= 1'b1;
                    mem_we_o     <= 1'b0;
                    state        <= RD_REQ;
                end
                RD_REQ: if (mem_gnt_i) begin
                    mem_req_o <= 1'b0;
                    state     <= RD_WAIT;
                end
                // A failed read or an unknown opcode aborts before any write is issued
                RD_WAIT: if (timeout || (mem_rvalid_i && (mem_err_i || !op_defined(op)))) begin
                    rsp_error_o <= 1'b1;
                    rsp_data_o  <= '0;
                    rsp_valid_o <= 1'b1;
                    lock_o      <= 1'b0;
                    state       <= RESP;
                end else if (mem_rvalid_i) begin
                    old        <= mem_rdata_i;
                    rsp_data_o <= mem_rdata_i;
                    mem_req_o  <= 1'b1;
                    mem_we_o   <= 1'b1;
                    state      <= WR_REQ;
                end
                WR_REQ: if (mem_gnt_i) begin
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                    state     <= WR_WAIT;
                end
                WR_WAIT: if (mem_rvalid_i || timeout) begin
                    rsp_error_o <= rsp_error_o | timeout | (mem_rvalid_i & mem_err_i);
                    if (timeout) rsp_data_o <= '0;
                    rsp_valid_o <= 1'b1;
                    lock_o      <= 1'b0;
                    state       <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tluh_lu_atomic_ctrl.sv
// tb_tluh_lu_atomic_ctrl: directed and randomized atomics against a word-level memory model.
module tb_tluh_lu_atomic_ctrl;
    import tluh_pkg::*;
    localparam int AW = 32, SRCW = 8, TMO = 8;

    logic              clk_i = 1'b0, rst_i = 1'b0;
    logic              req_valid_i = 1'b0, req_ready_o;
    logic [AW-1:0]     req_addr_i = '0;
    logic [31:0]       req_data_i = '0;
    logic [3:0]        req_mask_i = '0;
    logic [2:0]        req_op_i = '0;
    logic [SRCW-1:0]   req_source_i = '0;
    logic              rsp_valid_o, rsp_ready_i = 1'b0, rsp_error_o;
    logic [31:0]       rsp_data_o;
    logic [SRCW-1:0]   rsp_source_o;
    logic              mem_req_o, mem_we_o, lock_o;
    logic [AW-1:0]     mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_wmask_o;
    logic              mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
    logic [31:0]       mem_rdata_i = '0;

    tluh_lu_atomic_ctrl #(.AW(AW), .SRCW(SRCW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_mask_i(req_mask_i), .req_op_i(req_op_i),
        .req_source_i(req_source_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_source_o(rsp_source_o), .rsp_error_o(rsp_error_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .lock_o(lock_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0, n_fail = 0;
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    int n_wr = 0, we_seen = 0;
    logic [AW-1:0] raddr = '0, waddr = '0;
    int gnt_stall = 0, rv_delay = 0;
    bit rd_err_k = 0, wr_err_k = 0, drop_rsp = 0, late_rv = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] apply_atomic(input logic [31:0] o, input logic [31:0] d,
                                                 input logic [3:0] m, input logic [2:0] op);
        logic [31:0] r, res;
        r = op == 3'd0 ? o ^ d : op == 3'd1 ? o | d : op == 3'd2 ? o & d : d;
        for (int i = 0; i < 4; i++) res[i*8 +: 8] = m[i] ? r[i*8 +: 8] : o[i*8 +: 8];
        return res;
    endfunction

    // Memory slave: grants after gnt_stall cycles, responds rv_delay cycles after grant
    initial begin
        bit pend = 0, seen = 0, pend_err = 0;
        int pend_dly = 0, stall_left = 0;
        logic [31:0] pend_data = '0;
        forever begin
            @(negedge clk_i);
            mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
            if (rst_i) begin
                pend = 0; seen = 0;
            end else begin
                if (mem_we_o) we_seen++;
                if (pend) begin
                    if (pend_dly == 0) begin
                        if (!drop_rsp) begin
                            mem_rvalid_i = 1; mem_rdata_i = pend_data; mem_err_i = pend_err;
                        end
                        pend = 0;
                    end else pend_dly--;
                end
                if (late_rv) begin
                    mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF; mem_err_i = 1; late_rv = 0;
                end
                if (mem_req_o) begin
                    if (!seen) begin seen = 1; stall_left = gnt_stall; end
                    if (stall_left > 0) stall_left--;
                    else begin
                        mem_gnt_i = 1; seen = 0; pend = 1; pend_dly = rv_delay;
                        if (mem_we_o) begin
                            n_wr++; waddr = mem_addr_o; pend_data = '0; pend_err = wr_err_k;
                            for (int i = 0; i < 4; i++)
                                if (mem_wmask_o[i]) mem[mem_addr_o[4:0]][i*8 +: 8] = mem_wdata_o[i*8 +: 8];
                        end else begin
                            raddr = mem_addr_o; pend_data = mem[mem_addr_o[4:0]]; pend_err = rd_err_k;
                        end
                    end
                end
            end
        end
    end

    // Issues one atomic and checks response, timing, lock and resulting memory; entered just after a negedge
    task automatic run_atomic(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m,
                              input logic [2:0] op, input logic [SRCW-1:0] src, input int stall,
                              input int dly, input bit rerr, input bit werr, input bit tmo, input int hold);
        logic [31:0] old, exp_data;
        bit abort, exp_err;
        int exp_lat, lat, lock_bad, wr0, we0;
        old = ref_mem[a[4:0]];
        abort = rerr || tmo || op > 3'd3;
        exp_err = abort || werr;
        exp_data = abort ? 32'h0 : old;
        exp_lat = tmo ? 2 + stall + TMO : abort ? 3 + stall + dly : 5 + 2 * stall + 2 * dly;
        if (!abort) ref_mem[a[4:0]] = apply_atomic(old, d, m, op);
        gnt_stall = stall; rv_delay = dly; rd_err_k = rerr; wr_err_k = werr; drop_rsp = tmo;
        wr0 = n_wr; we0 = we_seen;
        check("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1; req_addr_i = a; req_data_i = d; req_mask_i = m; req_op_i = op; req_source_i = src;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 0; lat = 1; lock_bad = 0;
        while (!rsp_valid_o && lat < 100) begin
            if (!lock_o) lock_bad++;
            @(negedge clk_i);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_data", rsp_data_o, exp_data);
        check("rsp_error", rsp_error_o, exp_err);
        check("rsp_source", rsp_source_o, src);
        check("lock_held", lock_bad, 0);
        check("lock_released", lock_o, 0);
        repeat (hold) begin
            @(negedge clk_i);
            check("hold_valid", rsp_valid_o, 1);
            check("hold_data", rsp_data_o, exp_data);
            check("hold_error", rsp_error_o, exp_err);
            check("hold_source", rsp_source_o, src);
        end
        rsp_ready_i = 1;
        @(negedge clk_i);
        rsp_ready_i = 0; drop_rsp = 0;
        check("rsp_done", {rsp_valid_o, req_ready_o}, 2'b01);
        check("write_count", n_wr - wr0, abort ? 0 : 1);
        check("we_seen", we_seen > we0, !abort);
        check("rd_addr", raddr, a);
        if (!abort) check("wr_addr", waddr, a);
        check("mem_word", mem[a[4:0]], ref_mem[a[4:0]]);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 32; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        #1 rst_i = 1;
        repeat (2) @(negedge clk_i);
        check("rst_ready", req_ready_o, 1);
        check("rst_outs", {rsp_valid_o, rsp_error_o, mem_req_o, mem_we_o, lock_o}, 0);
        check("rst_data", {rsp_data_o, mem_wdata_o}, 0);
        rst_i = 0;
        @(negedge clk_i);
        check("post_rst_idle", {req_ready_o, lock_o, mem_req_o}, 3'b100);

        mem[16] = 32'hF0F0_F0F0; ref_mem[16] = mem[16];
        run_atomic(16, 32'hFFFF_0000, 4'hF, LOGIC_XOR, 8'h11, 0, 0, 0, 0, 0, 0);
        check("xor_result", mem[16], 32'h0F0F_F0F0);
        mem[3] = 32'hAABB_CCDD; ref_mem[3] = mem[3];
        run_atomic(3, 32'h0000_00F0, 4'h3, LOGIC_AND, 8'h22, 0, 0, 0, 0, 0, 1);
        check("and_result", mem[3], 32'hAABB_00D0);
        mem[4] = 32'h1234_5678; ref_mem[4] = mem[4];
        run_atomic(4, 32'hDEAD_BEEF, 4'hF, LOGIC_SWAP, 8'h33, 3, 0, 0, 0, 0, 0);
        check("swap_result", mem[4], 32'hDEAD_BEEF);
        run_atomic(9, 32'h5555_5555, 4'hF, LOGIC_OR, 8'hA5, 0, 1, 1, 0, 0, 4);
        run_atomic(2, 32'h1111_1111, 4'hF, 3'd5, 8'h44, 1, 0, 0, 0, 0, 2);
        run_atomic(6, 32'hFFFF_FFFF, 4'h0, LOGIC_XOR, 8'h55, 0, 0, 0, 0, 0, 0);
        run_atomic(8, 32'h0F00_00F0, 4'hC, LOGIC_OR, 8'h66, 2, 2, 0, 1, 0, 1);

        // Reset while the write phase is stalled waiting for a grant
        mem[5] = 32'h0000_0001; ref_mem[5] = mem[5];
        gnt_stall = 6; rv_delay = 0; rd_err_k = 0; wr_err_k = 0;
        req_valid_i = 1; req_addr_i = 5; req_data_i = 32'h8000_0000; req_mask_i = 4'hF;
        req_op_i = LOGIC_OR; req_source_i = 8'h77;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 0; w = 0;
        while (!mem_we_o && w < 100) begin @(negedge clk_i); w++; end
        check("reach_wr_req", mem_we_o, 1);
        rst_i = 1;
        #1;
        check("midrst_outs", {rsp_valid_o, mem_req_o, mem_we_o, lock_o}, 0);
        check("midrst_ready", req_ready_o, 1);
        check("midrst_wdata", {mem_wdata_o, mem_wmask_o}, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        repeat (3) begin
            @(negedge clk_i);
            check("midrst_no_rsp", rsp_valid_o, 0);
        end
        check("midrst_mem", mem[5], 32'h0000_0001);
        run_atomic(5, 32'h8000_0000, 4'hF, LOGIC_OR, 8'h78, 0, 0, 0, 0, 0, 0);
        check("or_after_rst", mem[5], 32'h8000_0001);

`ifdef TLUH_ATOMIC_TIMEOUT_EN
        run_atomic(7, 32'h0000_0001, 4'hF, LOGIC_OR, 8'h99, 0, 0, 0, 0, 1, 0);
        late_rv = 1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("late_rv_ignored", {rsp_valid_o, lock_o, mem_req_o, req_ready_o}, 4'b0001);
        run_atomic(7, 32'h0000_0100, 4'hF, LOGIC_XOR, 8'h9A, 0, 0, 0, 0, 0, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            logic [2:0] rop;
            rop = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            run_atomic(AW'($urandom_range(0, 31)), $urandom, 4'($urandom), rop, SRCW'($urandom),
                       $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 7) == 0,
                       $urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
